// File: rtl/pin_in_filter.sv
// Input pin conditioning: per-pin synchroniser, programmable glitch filter,
// and a valid/ready change-event word with sticky overflow reporting.
module pin_in_filter #(
  parameter int WIDTH       = 32,
  parameter int FILT_BITS   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock_160,
  input  logic                 res,
  input  logic [WIDTH-1:0]     pin_raw,
  input  logic [WIDTH-1:0]     filt_en,
  input  logic [FILT_BITS-1:0] filt_len,
  output logic [WIDTH-1:0]     pin_in,
  input  logic [WIDTH-1:0]     evt_mask,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [WIDTH-1:0]     evt_bits,
  output logic                 evt_overflow
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] pin_chg;

  always_ff @(posedge clock_160) begin
    if (res) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= pin_raw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // One glitch filter per pin; pin_chg flags the cycle a new level is taken.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_filt
    logic [FILT_BITS-1:0] cnt_q, cnt_d;
    logic                 lvl_q, lvl_d;

    always_comb begin
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      if (!filt_en[gi]) begin
        lvl_d = sync_s[gi];
        cnt_d = '0;
      end else if (sync_s[gi] == lvl_q) begin
        cnt_d = '0;
      end else if (cnt_q >= filt_len) begin
        lvl_d = sync_s[gi];
        cnt_d = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clock_160) begin
      if (res) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
      end
    end

    assign pin_in[gi]  = lvl_q;
    assign pin_chg[gi] = lvl_d ^ lvl_q;
  end

  logic [WIDTH-1:0] chg_q;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] bits_q, bits_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] acc;
  logic             ovf_new;

  assign acc = pend_q | chg_q;

  always_comb begin
    valid_d = valid_q;
    bits_d  = bits_q;
    pend_d  = pend_q;
    ovf_new = (|(chg_q & pend_q)) ||
              (valid_q && !evt_ready && (|(chg_q & bits_q)));
    if (!valid_q) begin
      if (|acc) begin
        bits_d  = acc;
        valid_d = 1'b1;
        pend_d  = '0;
      end
    end else begin
      pend_d = pend_q | chg_q;
      if (evt_ready) valid_d = 1'b0;
    end
    // A fresh overflow beats the clear-on-accept.
    if (ovf_new)                    ovf_d = 1'b1;
    else if (valid_q && evt_ready)  ovf_d = 1'b0;
    else                            ovf_d = ovf_q;
  end

  always_ff @(posedge clock_160) begin
    if (res) begin
      chg_q   <= '0;
      pend_q  <= '0;
      bits_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      chg_q   <= pin_chg & evt_mask;
      pend_q  <= pend_d;
      bits_q  <= bits_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign evt_valid    = valid_q;
  assign evt_bits     = bits_q;
  assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_pin_in_filter.sv
// Directed bench for pin_in_filter: vector table for bypass, glitch and
// overflow timing, plus hand sequences for merge, backpressure and reset.
module tb_pin_in_filter;

  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        res;
  logic [31:0] pin_raw, filt_en, evt_mask, pin_in, evt_bits;
  logic [3:0]  filt_len;
  logic        evt_valid, evt_ready, evt_overflow;

  int n_cmp = 0;
  int n_bad = 0;

  pin_in_filter #(.WIDTH(32), .FILT_BITS(4), .SYNC_STAGES(2)) dut (
    .clock_160    (clk),
    .res          (res),
    .pin_raw      (pin_raw),
    .filt_en      (filt_en),
    .filt_len     (filt_len),
    .pin_in       (pin_in),
    .evt_mask     (evt_mask),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_bits     (evt_bits),
    .evt_overflow (evt_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] raw;
    logic [31:0] en;
    logic [3:0]  len;
    logic [31:0] mask;
    logic        rdy;
    int          n;
    logic [31:0] e_pin;
    logic        e_valid;
    logic [31:0] e_bits;
    logic        e_ovf;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t mk(logic [31:0] raw, logic [31:0] en, logic [3:0] len,
                              logic [31:0] mask, logic rdy, int n, logic [31:0] e_pin,
                              logic e_valid, logic [31:0] e_bits, logic e_ovf);
    vec_t v;
    v.raw = raw; v.en = en; v.len = len; v.mask = mask; v.rdy = rdy; v.n = n;
    v.e_pin = e_pin; v.e_valid = e_valid; v.e_bits = e_bits; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  logic [31:0] toggled, prev_raw, held, uni;
  logic        seen;
  int          viol;

  initial begin
    // Bypass, glitch reject, overflow; each row waits n cycles then compares.
    tbl[0]  = mk(32'h20, 0,   0, ALL, 0, 2, 32'h00, 0, 0, 0);
    tbl[1]  = mk(32'h20, 0,   0, ALL, 0, 1, 32'h20, 0, 0, 0);
    tbl[2]  = mk(32'h20, 0,   0, ALL, 0, 1, 32'h20, 1, 32'h20, 0);
    tbl[3]  = mk(32'h20, 0,   0, ALL, 1, 1, 32'h20, 0, 0, 0);
    tbl[4]  = mk(32'h21, ALL, 3, ALL, 0, 3, 32'h20, 0, 0, 0);
    tbl[5]  = mk(32'h20, ALL, 3, ALL, 0, 6, 32'h20, 0, 0, 0);
    tbl[6]  = mk(32'h21, ALL, 3, ALL, 0, 4, 32'h20, 0, 0, 0);
    tbl[7]  = mk(32'h20, ALL, 3, ALL, 0, 1, 32'h20, 0, 0, 0);
    tbl[8]  = mk(32'h20, ALL, 3, ALL, 0, 1, 32'h21, 0, 0, 0);
    tbl[9]  = mk(32'h20, ALL, 3, ALL, 0, 1, 32'h21, 1, 32'h01, 0);
    tbl[10] = mk(32'h20, ALL, 3, ALL, 1, 1, 32'h21, 0, 0, 0);
    tbl[11] = mk(32'h20, ALL, 3, ALL, 0, 2, 32'h20, 0, 0, 0);
    tbl[12] = mk(32'h20, ALL, 3, ALL, 0, 1, 32'h20, 1, 32'h01, 0);
    tbl[13] = mk(32'h20, ALL, 3, ALL, 1, 1, 32'h20, 0, 0, 0);
    tbl[14] = mk(32'h24, 0,   0, ALL, 0, 4, 32'h24, 1, 32'h04, 0);
    tbl[15] = mk(32'h24, 0,   0, ALL, 0, 6, 32'h24, 1, 32'h04, 0);
    tbl[16] = mk(32'h20, 0,   0, ALL, 0, 3, 32'h20, 1, 32'h04, 0);
    tbl[17] = mk(32'h20, 0,   0, ALL, 0, 1, 32'h20, 1, 32'h04, 1);
    tbl[18] = mk(32'h20, 0,   0, ALL, 1, 1, 32'h20, 0, 0, 0);
    tbl[19] = mk(32'h20, 0,   0, ALL, 0, 1, 32'h20, 1, 32'h04, 0);
    tbl[20] = mk(32'h20, 0,   0, ALL, 1, 1, 32'h20, 0, 0, 0);
    tbl[21] = mk(32'h20, 0,   0, ALL, 0, 3, 32'h20, 0, 0, 0);

    res = 1'b1; pin_raw = '0; filt_en = '0; filt_len = '0;
    evt_mask = ALL; evt_ready = 1'b0;
    tick(3);
    chk("reset pin_in", pin_in, 0);
    chk("reset valid", {31'b0, evt_valid}, 0);
    chk("reset bits", evt_bits, 0);
    chk("reset ovf", {31'b0, evt_overflow}, 0);
    res = 1'b0;
    tick(2);
    chk("idle valid", {31'b0, evt_valid}, 0);

    for (int i = 0; i < NV; i++) begin
      pin_raw = tbl[i].raw; filt_en = tbl[i].en; filt_len = tbl[i].len;
      evt_mask = tbl[i].mask; evt_ready = tbl[i].rdy;
      tick(tbl[i].n);
      $display("vec %0d: pin_in=%h valid=%0d bits=%h ovf=%0d",
               i, pin_in, evt_valid, evt_bits, evt_overflow);
      chk($sformatf("vec%0d pin_in", i), pin_in, tbl[i].e_pin);
      chk($sformatf("vec%0d valid", i), {31'b0, evt_valid}, {31'b0, tbl[i].e_valid});
      if (tbl[i].e_valid) chk($sformatf("vec%0d bits", i), evt_bits, tbl[i].e_bits);
      chk($sformatf("vec%0d ovf", i), {31'b0, evt_overflow}, {31'b0, tbl[i].e_ovf});
    end

    // Merge and mask: pins 1,3,9 together, only 1 and 3 enabled for events.
    evt_mask = 32'h0000_00FF; pin_raw = 32'h22A;
    tick(3);
    chk("merge pin_in", pin_in, 32'h22A);
    chk("merge early valid", {31'b0, evt_valid}, 0);
    tick(1);
    $display("merge: valid=%0d bits=%h", evt_valid, evt_bits);
    chk("merge valid", {31'b0, evt_valid}, 1);
    chk("merge bits", evt_bits, 32'h0A);
    evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
    tick(4);
    chk("merge no pin9 word", {31'b0, evt_valid}, 0);
    pin_raw = 32'h20;
    tick(4);
    chk("merge fall pin_in", pin_in, 32'h20);
    chk("merge fall bits", evt_valid ? evt_bits : 32'hDEAD, 32'h0A);
    evt_ready = 1'b1; tick(1); evt_ready = 1'b0; evt_mask = ALL;
    tick(2);

    // Backpressure: random activity on pins 8..15 with ready low for 50 cycles.
    toggled = '0; prev_raw = pin_raw; seen = 1'b0; held = '0; viol = 0;
    for (int c = 0; c < 50; c++) begin
      if (c < 40) pin_raw = {16'h0, 8'($urandom_range(0, 255)), 8'h20};
      else        pin_raw = 32'h20;
      toggled  = toggled | (pin_raw ^ prev_raw);
      prev_raw = pin_raw;
      tick(1);
      if (evt_valid) begin
        if (seen && evt_bits !== held) viol++;
        held = evt_bits;
        seen = 1'b1;
      end
    end
    $display("backpressure: toggled=%h held=%h", toggled, held);
    chk("bp bits stable", viol, 0);
    chk("bp overflow", {31'b0, evt_overflow}, 1);
    evt_ready = 1'b1; uni = '0;
    for (int c = 0; c < 20; c++) begin
      if (evt_valid) uni = uni | evt_bits;
      tick(1);
    end
    evt_ready = 1'b0;
    $display("backpressure release: delivered=%h", uni);
    chk("bp delivered", uni, toggled);
    chk("bp drained", {31'b0, evt_valid}, 0);
    chk("bp ovf cleared", {31'b0, evt_overflow}, 0);

    // Reset mid-operation: word pending, pend non-zero, pin 0 counter running.
    filt_en = 32'h1; filt_len = 4'd15; pin_raw = 32'h23;
    tick(4);
    chk("rst pre bits", evt_valid ? evt_bits : 32'hDEAD, 32'h02);
    pin_raw = 32'h21;
    tick(4);
    chk("rst pre pin_in", pin_in, 32'h20);
    chk("rst pre ovf", {31'b0, evt_overflow}, 1);
    res = 1'b1; pin_raw = 32'h20; filt_en = '0;
    tick(1);
    res = 1'b0;
    $display("mid reset: pin_in=%h valid=%0d bits=%h ovf=%0d",
             pin_in, evt_valid, evt_bits, evt_overflow);
    chk("rst pin_in", pin_in, 0);
    chk("rst valid", {31'b0, evt_valid}, 0);
    chk("rst bits", evt_bits, 0);
    chk("rst ovf", {31'b0, evt_overflow}, 0);
    tick(2);
    chk("rst sync pin_in", pin_in, 0);
    chk("rst no stale", {31'b0, evt_valid}, 0);
    tick(1);
    chk("rst rise pin_in", pin_in, 32'h20);
    chk("rst rise early", {31'b0, evt_valid}, 0);
    tick(1);
    chk("rst rise bits", evt_valid ? evt_bits : 32'hDEAD, 32'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pin_in_filter.md
Name: pin_in_filter

Overview:
- Input-direction counterpart of the tristate pin output path: conditions the raw external pin bus before it reaches the p1v pin_in port.
- Per pin: metastability synchroniser, then a per-pin programmable glitch filter.
- Detects filtered pin changes and presents them as a change-event word over a valid/ready handshake, with sticky overflow reporting.

Parameters:
- WIDTH, 32, number of pins.
- FILT_BITS, 4, width of filt_len and of each per-pin stability counter.
- SYNC_STAGES, 2, synchroniser flop count per pin (minimum 2).

Ports:
- clock_160  input  1  system clock.
- res  input  1  synchronous active-high reset.
- pin_raw  input  WIDTH  asynchronous external pin levels.
- filt_en  input  WIDTH  per-pin filter enable; 0 = bypass.
- filt_len  input  FILT_BITS  extra stable cycles required before a filtered pin accepts a new level.
- pin_in  output  WIDTH  conditioned pin levels, to p1v.
- evt_mask  input  WIDTH  per-pin change-event enable.
- evt_valid  output  1  change word available.
- evt_ready  input  1  consumer accepts the word.
- evt_bits  output  WIDTH  pins that changed since the last accepted word.
- evt_overflow  output  1  a pin changed again while its previous change was still undelivered.

Behaviour:
- Reset (res=1 at a clock edge) clears the following to 0:
  - synchroniser flops, pin_in, all counters, pend register;
  - evt_valid, evt_bits, evt_overflow.
  - Undelivered events are discarded.
- Synchroniser: SYNC_STAGES flops per pin; s = last stage.
- Filter, per pin i, each cycle:
  - filt_en[i]=0: pin_in[i] <= s[i]; cnt[i] <= 0.
  - filt_en[i]=1, s[i]==pin_in[i]: cnt[i] <= 0.
  - filt_en[i]=1, s[i]!=pin_in[i], cnt[i] >= filt_len: pin_in[i] <= s[i]; cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i]+1. The counter saturates at all-ones and never wraps.
  - The >= comparison means a filt_len decrease mid-count takes effect immediately.
- Latency, raw edge to pin_in:
  - bypass: SYNC_STAGES+1 cycles;
  - filtered: SYNC_STAGES+filt_len+1 cycles, provided the level is held stable throughout.
  - A pulse shorter than filt_len+1 synchronised cycles is suppressed entirely.
- Change detect: chg[i] = 1 in the cycle pin_in[i] is updated to a new value, AND evt_mask[i].
  - evt_mask gates detection only; it does not clear pend or evt_bits.
- Event handshake:
  - acc = pend | chg.
  - evt_valid=0 and acc!=0: next cycle evt_bits <= acc, evt_valid <= 1, pend <= 0.
  - evt_valid=1: evt_bits held stable; pend <= pend | chg.
  - Overflow: evt_overflow <= 1 (sticky) if any chg bit is already set in pend, or in evt_bits while evt_valid=1 and evt_ready=0.
  - evt_valid=1 and evt_ready=1: evt_valid <= 0. evt_overflow is cleared in the same cycle unless a new overflow occurs in that cycle; a new overflow wins.
  - Throughput: at most one word per 2 cycles. After acceptance, pend is loaded on the following cycle when non-zero.
  - evt_ready while evt_valid=0 is ignored.
- Post-reset: a pin held high during reset produces a change event once pin_in rises. This is intended, not suppressed.
- Simultaneous changes on multiple pins in one cycle merge into one word.

Test Plan:
- Bypass: filt_en=0, pin_raw[5] 0->1 at cycle 0 -> pin_in[5]=1 at cycle 3. One word evt_bits=0x20 with evt_valid=1 at cycle 4; evt_ready=1 -> evt_valid=0 next cycle.
- Glitch reject: filt_en=all-ones, filt_len=3.
  - 3-cycle high pulse on pin 0 -> pin_in[0] stays 0; no event.
  - 4-cycle hold -> pin_in[0]=1 exactly 6 cycles after the raw edge.
- Overflow: evt_ready=0, pin 2 toggles 0->1->0 (bypass, 10 cycles apart).
  - Expect first word evt_bits=0x4, then evt_overflow=1.
  - Accept -> second word 0x4, evt_overflow=0 after acceptance.
- Merge/mask: evt_mask=0x0000_00FF. Pins 1, 3 and 9 change in the same cycle -> single word evt_bits=0x0A; pin_in[9] still updates.
- Backpressure stability: hold evt_ready=0 for 50 cycles during random pin activity -> evt_bits constant while evt_valid=1; pending bits delivered after release.
- Reset mid-operation: assert res with evt_valid=1, pend!=0 and a counter mid-count -> all outputs 0 the next cycle; no stale event after res deasserts unless pins are actually high.
